bank_wait: RTL and testbench

BANK_WAIT -- requirements
Module: bank_wait

---
 rtl/bank_wait_pkg.sv | 18 +
 rtl/bank_wait_ctr.sv | 25 ++
 rtl/bank_wait.sv | 103 ++++++++++
 tb/tb_bank_wait.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/bank_wait_pkg.sv
// Shared definitions for the bank wait-state generator: FSM encoding,
// configuration byte layout and the default slow-bank threshold.
package bank_wait_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   localparam int CFG_ENABLE_BIT = 7;
   localparam int CFG_WAIT_MSB   = 2;
   localparam int CFG_WAIT_LSB   = 0;

   localparam logic [7:0] SLOW_BANK_MIN_DEFAULT = 8'h10;
   localparam logic [2:0] RESET_WAIT_DEFAULT    = 3'd1;

endpackage

// File: rtl/bank_wait_ctr.sv
// 3-bit loadable down-counter tracking the remaining wait cycles of a stall.
module bank_wait_ctr (
   input  logic       clock,
   input  logic       reset,
   input  logic       load,
   input  logic [2:0] load_value,
   input  logic       dec,
   output logic [2:0] count,
   output logic       zero
);

   // Load takes priority over decrement; reset clears the count.
   always_ff @(posedge clock) begin
      if (reset) begin
         count <= 3'd0;
      end else if (load) begin
         count <= load_value;
      end else if (dec) begin
         count <= count - 3'd1;
      end
   end

   assign zero = (count == 3'd0);

endmodule

// File: rtl/bank_wait.sv
// Wait-state generator: stretches CPU accesses to slow banks by pulling
// ready low for a programmable number of bus cycles.
module bank_wait
   import bank_wait_pkg::*;
#(
   parameter logic [7:0] SLOW_BANK_MIN = SLOW_BANK_MIN_DEFAULT,
   parameter logic [2:0] RESET_WAIT    = RESET_WAIT_DEFAULT
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] address_bank,
   input  logic       valid,
   input  logic       be,
   input  logic       _rdy_in,
   input  logic       cfg_we,
   input  logic [7:0] cfg_data,
   output logic       _rdy_out,
   output logic       stalling,
   output logic [3:0] wait_cfg
);

   state_t     state;
   logic       enable;
   logic [2:0] wait_count;
   logic [2:0] ctr;
   logic       ctr_zero;
   logic       slow_bank;
   logic       hit;
   logic       stall;
   logic       ctr_load;
   logic [2:0] ctr_load_value;
   logic       ctr_dec;
   logic       unused_cfg_bits;

   assign unused_cfg_bits = ^cfg_data[CFG_ENABLE_BIT-1:CFG_WAIT_MSB+1];

   // Hit detection and stall generation; a released bus (be=0) never stalls.
   always_comb begin
      slow_bank      = (address_bank >= SLOW_BANK_MIN);
      hit            = (state == ST_IDLE) && enable && be && valid &&
                       slow_bank && (wait_count != 3'd0);
      stall          = hit || ((state == ST_WAIT) && be);
      ctr_load       = hit && (wait_count != 3'd1);
      ctr_load_value = wait_count - 3'd2;
      ctr_dec        = (state == ST_WAIT) && be && !ctr_zero;
   end

   assign _rdy_out = _rdy_in & ~stall;
   assign stalling = stall;
   assign wait_cfg = {enable, wait_count};

   // Configuration register; a write only affects hits that start later,
   // because the running sequence already holds its count in ctr.
   always_ff @(posedge clock) begin
      if (reset) begin
         enable     <= 1'b0;
         wait_count <= RESET_WAIT;
      end else if (cfg_we) begin
         enable     <= cfg_data[CFG_ENABLE_BIT];
         wait_count <= cfg_data[CFG_WAIT_MSB:CFG_WAIT_LSB];
      end
   end

   bank_wait_ctr u_ctr (
      .clock      (clock),
      .reset      (reset),
      .load       (ctr_load),
      .load_value (ctr_load_value),
      .dec        (ctr_dec),
      .count      (ctr),
      .zero       (ctr_zero)
   );

   // Sequencer: the hit cycle is the first stall cycle, WAIT covers the rest,
   // RELEASE holds until the board is ready so the held address never re-triggers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (hit) begin
                  state <= (wait_count == 3'd1) ? ST_RELEASE : ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (!be) begin
                  state <= ST_IDLE;
               end else if (ctr_zero) begin
                  state <= ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               if (_rdy_in) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bank_wait.sv
// Table-driven bench for bank_wait with hand-computed per-cycle expectations.
module tb_bank_wait;

   typedef struct {
      logic       cfg_we;
      logic [7:0] cfg_data;
      logic [7:0] bank;
      logic       valid;
      logic       be;
      logic       rdy_in;
      logic       rst;
      logic       exp_rdy;
      logic       exp_stall;
      logic [3:0] exp_cfg;
   } vec_t;

   logic       clock;
   logic       reset;
   logic [7:0] address_bank;
   logic       valid;
   logic       be;
   logic       rdy_in;
   logic       cfg_we;
   logic [7:0] cfg_data;
   logic       rdy_out;
   logic       stalling;
   logic [3:0] wait_cfg;

   int checks;
   int failures;
   vec_t vecs[$];

   bank_wait dut (
      .clock        (clock),
      .reset        (reset),
      .address_bank (address_bank),
      .valid        (valid),
      .be           (be),
      ._rdy_in      (rdy_in),
      .cfg_we       (cfg_we),
      .cfg_data     (cfg_data),
      ._rdy_out     (rdy_out),
      .stalling     (stalling),
      .wait_cfg     (wait_cfg)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic addVec(input logic we, input logic [7:0] data, input logic [7:0] bank,
                         input logic v, input logic b, input logic rin, input logic rst,
                         input logic erdy, input logic estall, input logic [3:0] ecfg);
      vec_t t;
      t.cfg_we = we; t.cfg_data = data; t.bank = bank; t.valid = v; t.be = b;
      t.rdy_in = rin; t.rst = rst; t.exp_rdy = erdy; t.exp_stall = estall; t.exp_cfg = ecfg;
      vecs.push_back(t);
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 time unit later.
   task automatic applyStimulus(input vec_t v);
      @(negedge clock);
      cfg_we       = v.cfg_we;
      cfg_data     = v.cfg_data;
      address_bank = v.bank;
      valid        = v.valid;
      be           = v.be;
      rdy_in       = v.rdy_in;
      reset        = v.rst;
      #1;
   endtask

   task automatic checkOutput(input vec_t v, input int idx);
      checks++;
      if (rdy_out !== v.exp_rdy) begin
         failures++;
         $display("[TB] FAIL row%0d rdy_out: got %b expected %b", idx, rdy_out, v.exp_rdy);
      end
      checks++;
      if (stalling !== v.exp_stall) begin
         failures++;
         $display("[TB] FAIL row%0d stalling: got %b expected %b", idx, stalling, v.exp_stall);
      end
      checks++;
      if (wait_cfg !== v.exp_cfg) begin
         failures++;
         $display("[TB] FAIL row%0d wait_cfg: got %h expected %h", idx, wait_cfg, v.exp_cfg);
      end
   endtask

   initial begin
      int  stall_len;
      bit  done;
      vec_t idle_v;

      checks = 0;
      failures = 0;
      reset = 1'b1; cfg_we = 1'b0; cfg_data = 8'h00; address_bank = 8'h00;
      valid = 1'b0; be = 1'b1; rdy_in = 1'b1;
      repeat (2) @(negedge clock);

      //      we  data   bank   v  be rin rst  rdy stl cfg
      addVec(0, 8'h00, 8'h00, 0, 1, 1, 1,   1, 0, 4'h1);
      addVec(0, 8'h00, 8'h00, 0, 1, 0, 1,   0, 0, 4'h1);
      addVec(0, 8'h00, 8'h12, 1, 1, 1, 0,   1, 0, 4'h1);
      addVec(1, 8'h83, 8'h00, 0, 1, 1, 0,   1, 0, 4'h1);
      // three-cycle stall on bank 12, then release
      addVec(0, 8'h00, 8'h12, 1, 1, 1, 0,   0, 1, 4'hB);
      addVec(0, 8'h00, 8'h12, 1, 1, 1, 0,   0, 1, 4'hB);
      addVec(0, 8'h00, 8'h12, 1, 1, 1, 0,   0, 1, 4'hB);
      addVec(0, 8'h00, 8'h12, 1, 1, 1, 0,   1, 0, 4'hB);
      addVec(0, 8'h00, 8'h00, 0, 1, 1, 0,   1, 0, 4'hB);
      // bank threshold: 0F fast, 10 slow
      addVec(0, 8'h00, 8'h0F, 1, 1, 1, 0,   1, 0, 4'hB);
      addVec(0, 8'h00, 8'h0F, 1, 1, 1, 0,   1, 0, 4'hB);
      addVec(0, 8'h00, 8'h10, 1, 1, 1, 0,   0, 1, 4'hB);
      addVec(0, 8'h00, 8'h00, 0, 1, 1, 0,   0, 1, 4'hB);
      addVec(0, 8'h00, 8'h00, 0, 1, 1, 0,   0, 1, 4'hB);
      addVec(0, 8'h00, 8'h00, 0, 1, 1, 0,   1, 0, 4'hB);
      addVec(0, 8'h00, 8'h00, 0, 1, 1, 0,   1, 0, 4'hB);
      // bank FF is slow
      addVec(0, 8'h00, 8'hFF, 1, 1, 1, 0,   0, 1, 4'hB);
      addVec(0, 8'h00, 8'h00, 0, 1, 1, 0,   0, 1, 4'hB);
      addVec(0, 8'h00, 8'h00, 0, 1, 1, 0,   0, 1, 4'hB);
      addVec(0, 8'h00, 8'h00, 0, 1, 1, 0,   1, 0, 4'hB);
      addVec(0, 8'h00, 8'h00, 0, 1, 1, 0,   1, 0, 4'hB);
      // bus released: no hit
      addVec(0, 8'h00, 8'h12, 1, 0, 1, 0,   1, 0, 4'hB);
      // wait 1, back-to-back slow accesses
      addVec(1, 8'h81, 8'h00, 0, 1, 1, 0,   1, 0, 4'hB);
      addVec(0, 8'h00, 8'h12, 1, 1, 1, 0,   0, 1, 4'h9);
      addVec(0, 8'h00, 8'h12, 1, 1, 1, 0,   1, 0, 4'h9);
      addVec(0, 8'h00, 8'h12, 1, 1, 1, 0,   0, 1, 4'h9);
      addVec(0, 8'h00, 8'h12, 1, 1, 1, 0,   1, 0, 4'h9);
      addVec(0, 8'h00, 8'h00, 0, 1, 1, 0,   1, 0, 4'h9);
      // wait 2 with external stretch for 4 cycles
      addVec(1, 8'h82, 8'h00, 0, 1, 1, 0,   1, 0, 4'h9);
      addVec(0, 8'h00, 8'h12, 1, 1, 0, 0,   0, 1, 4'hA);
      addVec(0, 8'h00, 8'h12, 1, 1, 0, 0,   0, 1, 4'hA);
      addVec(0, 8'h00, 8'h12, 1, 1, 0, 0,   0, 0, 4'hA);
      addVec(0, 8'h00, 8'h12, 1, 1, 0, 0,   0, 0, 4'hA);
      addVec(0, 8'h00, 8'h00, 0, 1, 1, 0,   1, 0, 4'hA);
      addVec(0, 8'h00, 8'h00, 0, 1, 1, 0,   1, 0, 4'hA);
      // wait count 0 is transparent
      addVec(1, 8'h80, 8'h00, 0, 1, 1, 0,   1, 0, 4'hA);
      addVec(0, 8'h00, 8'h12, 1, 1, 1, 0,   1, 0, 4'h8);
      addVec(0, 8'h00, 8'h12, 1, 1, 0, 0,   0, 0, 4'h8);
      // wait 7, reconfigured to 1 mid-sequence
      addVec(1, 8'h87, 8'h00, 0, 1, 1, 0,   1, 0, 4'h8);
      addVec(0, 8'h00, 8'h12, 1, 1, 1, 0,   0, 1, 4'hF);
      addVec(1, 8'h81, 8'h00, 0, 1, 1, 0,   0, 1, 4'hF);
      for (int i = 0; i < 5; i++) addVec(0, 8'h00, 8'h00, 0, 1, 1, 0, 0, 1, 4'h9);
      addVec(0, 8'h00, 8'h00, 0, 1, 1, 0,   1, 0, 4'h9);
      addVec(0, 8'h00, 8'h12, 1, 1, 1, 0,   0, 1, 4'h9);
      addVec(0, 8'h00, 8'h00, 0, 1, 1, 0,   1, 0, 4'h9);
      // config write in the same cycle as a hit uses the old count
      addVec(1, 8'h83, 8'h12, 1, 1, 1, 0,   0, 1, 4'h9);
      addVec(0, 8'h00, 8'h00, 0, 1, 1, 0,   1, 0, 4'hB);
      addVec(0, 8'h00, 8'h12, 1, 1, 1, 0,   0, 1, 4'hB);
      addVec(0, 8'h00, 8'h00, 0, 1, 1, 0,   0, 1, 4'hB);
      addVec(0, 8'h00, 8'h00, 0, 1, 1, 0,   0, 1, 4'hB);
      addVec(0, 8'h00, 8'h00, 0, 1, 1, 0,   1, 0, 4'hB);
      // wait 5 aborted by be=0, then by reset
      addVec(1, 8'h85, 8'h00, 0, 1, 1, 0,   1, 0, 4'hB);
      addVec(0, 8'h00, 8'h12, 1, 1, 1, 0,   0, 1, 4'hD);
      addVec(0, 8'h00, 8'h00, 0, 0, 1, 0,   1, 0, 4'hD);
      addVec(0, 8'h00, 8'h00, 0, 1, 1, 0,   1, 0, 4'hD);
      addVec(0, 8'h00, 8'h12, 1, 1, 1, 0,   0, 1, 4'hD);
      addVec(0, 8'h00, 8'h00, 0, 1, 1, 1,   0, 1, 4'hD);
      addVec(0, 8'h00, 8'h00, 0, 1, 1, 0,   1, 0, 4'h1);
      addVec(0, 8'h00, 8'h00, 0, 1, 1, 0,   1, 0, 4'h1);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         checkOutput(vecs[i], i);
      end

      // Hand-written: measure the stall length for wait count 6 with a cycle budget.
      idle_v = '{cfg_we: 1'b1, cfg_data: 8'h86, bank: 8'h00, valid: 1'b0, be: 1'b1,
                 rdy_in: 1'b1, rst: 1'b0, exp_rdy: 1'b1, exp_stall: 1'b0, exp_cfg: 4'h1};
      applyStimulus(idle_v);
      @(negedge clock);
      cfg_we = 1'b0; address_bank = 8'h20; valid = 1'b1;
      #1;
      stall_len = 0;
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         if (stalling) stall_len++;
         else done = 1'b1;
         if (!done) begin
            @(negedge clock);
            valid = 1'b0;
            #1;
         end
      end
      checks++;
      if (!done) begin
         failures++;
         $display("[TB] FAIL stall6_timeout: got still stalling after 20 cycles, expected release");
      end
      checks++;
      if (stall_len != 6) begin
         failures++;
         $display("[TB] FAIL stall6_length: got %0d expected 6", stall_len);
      end
      checks++;
      if (wait_cfg !== 4'hE) begin
         failures++;
         $display("[TB] FAIL stall6_cfg: got %h expected e", wait_cfg);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
